// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: stage-count math and Baugh-Wooley correction constants.
package arith_pkg;

  // Ceiling log2, with clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Stage 0 registers the partial products; each later stage holds up to r ripple rows.
  function automatic int mult_stages(input int n, input int r);
    return (n - 1 + r - 1) / r + 1;
  endfunction

  // Baugh-Wooley correction ones sit at column N + BW_COL_LO_OFS and column 2N - BW_COL_HI_BACK.
  localparam int BW_COL_LO_OFS  = 0;
  localparam int BW_COL_HI_BACK = 1;
  localparam int BW_MAX_W       = 64;

  // Full 2N-bit correction constant for an N-bit signed product (N <= 32).
  function automatic logic [BW_MAX_W-1:0] bw_corr(input int n);
    logic [BW_MAX_W-1:0] v;
    v = '0;
    v[n + BW_COL_LO_OFS]      = 1'b1;
    v[2 * n - BW_COL_HI_BACK] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/array_mult_row.sv
// One carry-save ripple row of the array multiplier plus its adder cells.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Row i adds partial-product row i into the running sum/carry vectors.
// Incoming sum bit s_in[k+1] and carry c_in[k] both weigh the same as pp[k];
// the new sum bit 0 is settled and leaves as product bit i.
module array_mult_row #(
  parameter int N = 8
) (
  input  logic [N-1:1] s_in,
  input  logic [N-1:0] c_in,
  input  logic [N-1:0] pp,
  output logic [N-1:1] s_out,
  output logic [N-1:0] c_out,
  output logic         bit_out
);
  logic [N-1:0] sum;

  for (genvar k = 0; k < N - 1; k++) begin : g_fa
    full_adder u_fa (
      .a  (pp[k]),
      .b  (c_in[k]),
      .ci (s_in[k+1]),
      .s  (sum[k]),
      .co (c_out[k])
    );
  end

  // Top column has no incoming sum bit from above.
  half_adder u_ha (
    .a  (pp[N-1]),
    .b  (c_in[N-1]),
    .s  (sum[N-1]),
    .co (c_out[N-1])
  );

  assign s_out   = sum[N-1:1];
  assign bit_out = sum[0];
endmodule

// File: rtl/pipelined_array_multiplier.sv
// N x N carry-save array multiplier, registered every ROWS_PER_ST rows,
// unsigned or Baugh-Wooley signed per beat, valid/ready with global stall.
module pipelined_array_multiplier
  import arith_pkg::*;
#(
  parameter int N           = 8,
  parameter int ROWS_PER_ST = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   P,
  output logic [TAG_W-1:0] out_tag
);

  localparam int R = ROWS_PER_ST;
  localparam int S = mult_stages(N, ROWS_PER_ST);
  localparam logic [BW_MAX_W-1:0] BW_CORR = bw_corr(N);
  localparam logic [N-1:0]        CORR_HI = BW_CORR[2*N-1:N];

  // Stage that settles product bit / consumes pp row r (row 0 seeds stage 1).
  function automatic int row_stage(input int r);
    return (r == 0) ? 1 : (r - 1) / R + 1;
  endfunction

  logic                    adv;
  logic [S:0]              vld_pipe;
  logic [S-1:0]            sgn_q;
  logic [TAG_W-1:0]        tag_q [0:S-1];
  logic [N-1:0][N-1:0]     pp_d;
  logic [N-1:0][N-1:0]     pp_q  [0:S-2];
  logic [N-1:1]            s_q   [1:S-1];
  logic [N-1:0]            c_q   [1:S-1];
  logic [N-1:0]            lo_q  [1:S-1];
  logic [S-1:1][N-1:1]     st_s;
  logic [S-1:1][N-1:0]     st_c;
  logic [S-1:1][N-1:0]     lo_d;
  logic [N-1:1]            row_s_in [1:N-1];
  logic [N-1:0]            row_c_in [1:N-1];
  logic [N-1:1]            row_s    [1:N-1];
  logic [N-1:0]            row_c    [1:N-1];
  logic [N-1:0]            row_bit;
  logic [N-1:0]            upper;
  logic [2*N-1:0]          p_d;

  assign adv       = !vld_pipe[S] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[S];

  // Partial products; signed beats invert the mixed-sign terms (not the corner).
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp_d[i][j] = (A[j] & B[i]) ^ (in_signed & ((i == N - 1) != (j == N - 1)));
      end
    end
  end

  // Ripple rows 1..N-1; the first row of a stage reads that stage's input register.
  assign row_bit[0] = pp_q[0][0][0];
  for (genvar r = 1; r < N; r++) begin : g_row
    localparam int G     = row_stage(r);
    localparam bit FIRST = ((r - 1) % R) == 0;
    if (!FIRST) begin : g_chain
      assign row_s_in[r] = row_s[r-1];
      assign row_c_in[r] = row_c[r-1];
    end else if (G == 1) begin : g_seed
      assign row_s_in[r] = pp_q[0][0][N-1:1];
      assign row_c_in[r] = '0;
    end else begin : g_reg
      assign row_s_in[r] = s_q[G-1];
      assign row_c_in[r] = c_q[G-1];
    end
    array_mult_row #(.N(N)) u_row (
      .s_in    (row_s_in[r]),
      .c_in    (row_c_in[r]),
      .pp      (pp_q[G-1][r]),
      .s_out   (row_s[r]),
      .c_out   (row_c[r]),
      .bit_out (row_bit[r])
    );
  end

  // Per-stage register inputs: last row's vectors plus the settled low bits so far.
  for (genvar g = 1; g < S; g++) begin : g_st
    localparam int LAST = (g * R < N - 1) ? g * R : N - 1;
    assign st_s[g] = row_s[LAST];
    assign st_c[g] = row_c[LAST];
    for (genvar b = 0; b < N; b++) begin : g_lo
      if (row_stage(b) == g) begin : g_new
        assign lo_d[g][b] = row_bit[b];
      end else if (row_stage(b) < g) begin : g_old
        assign lo_d[g][b] = lo_q[g-1][b];
      end else begin : g_none
        assign lo_d[g][b] = 1'b0;
      end
    end
  end

  // Final carry-propagate row; the correction only affects the upper half.
  assign upper = {1'b0, s_q[S-1]} + c_q[S-1] + (sgn_q[S-1] ? CORR_HI : '0);
  assign p_d   = {upper, lo_q[S-1]};

  // Datapath stage registers: load only valid beats so bubbles never drag X forward.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        pp_q[0]  <= pp_d;
        sgn_q[0] <= in_signed;
        tag_q[0] <= in_tag;
      end
      for (int g = 1; g < S; g++) begin
        if (vld_pipe[g-1]) begin
          s_q[g]   <= st_s[g];
          c_q[g]   <= st_c[g];
          lo_q[g]  <= lo_d[g];
          sgn_q[g] <= sgn_q[g-1];
          tag_q[g] <= tag_q[g-1];
        end
      end
      for (int g = 1; g < S - 1; g++) begin
        if (vld_pipe[g-1]) pp_q[g] <= pp_q[g-1];
      end
    end
  end

  // Valid chain and output register: the only flops that see reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      P        <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[S-1:0], in_valid};
      if (vld_pipe[S-1]) begin
        P       <= p_d;
        out_tag <= tag_q[S-1];
      end
    end
  end

endmodule
